riscv_issue_scoreboard: RTL
===========================

// Module: riscv_issue_scoreboard
// PURPOSE
// - In-order issue controller placed between the instruction source and the RISC_V datapath input.
// - Tracks in-flight destination registers and stalls any instruction whose sources are still pending.
// - Stalled cycles issue a canonical NOP bubble, which removes RAW hazards (e.g. addi x5 then add x6,x5,x1).
// - Keeps a saturating stall counter for performance visibility.
// PARAMETERS
// - WB_LATENCY  3   cycles from issue_valid until the datapath register write is readable; range 1..7
// - STALL_W     16  width of stall_count
// PORTS
// - clk          in   1        rising-edge clock
// - rst_n        in   1        asynchronous active-low reset
// - in_valid     in   1        in_instr holds a valid instruction
// - in_instr     in   32       RV32I instruction word
// - in_ready     out  1        instruction is accepted this cycle when in_valid && in_ready
// - flush        in   1        synchronous flush: clears scoreboard and output stage
// - issue_valid  out  1        issue_instr holds a real, accepted instruction
// - issue_instr  out  32       instruction driven to RISC_V.in; NOP when not valid
// - stall_count  out  STALL_W  saturating count of hazard-stall cycles
// BEHAVIOUR
// - Reset: every busy_cnt is 0, issue_valid=0, issue_instr=32'h0000_0013 (addi x0,x0,0), stall_count=0.
// - Decode (opcode [6:0]):
//   - 0110011 R-type: reads rs1 [19:15] and rs2 [24:20]; writes rd [11:7].
//   - 0010011 I-ALU: reads rs1; writes rd.
//   - 0110111 LUI: writes rd only.
//   - Any other opcode, including all-zero: no reads, no write; accepted and passed through unchanged.
// - Scoreboard: busy_cnt[1..31], each $clog2(WB_LATENCY+1) bits. x0 is never busy and never marked busy.
// - Hazard: in_valid && (a used rs has busy_cnt != 0).
// - in_ready = !hazard && !flush. It is combinational from in_instr and the scoreboard, with no dependence on issue_valid.
// - Each clock, every nonzero busy_cnt decrements by 1.
// - On accept with a write and rd != 0, busy_cnt[rd] loads WB_LATENCY; the load wins over the decrement.
// - WAW (rd already busy, not read) is not a hazard; the counter simply reloads.
// - Output stage (1-cycle latency, registered):
//   - On accept: issue_valid <= 1, issue_instr <= in_instr.
//   - Otherwise: issue_valid <= 0, issue_instr <= NOP.
//   - The datapath has no backpressure, so the output stage advances every cycle.
// - Stall latency: a dependent instruction presented right after its producer is accepted exactly WB_LATENCY cycles later.
// - stall_count increments on each cycle with in_valid && hazard && !flush and saturates at all-ones; it is not cleared by flush.
// - Flush has priority over accept:
//   - All busy_cnt clear to 0, issue_valid <= 0, issue_instr <= NOP.
//   - in_ready is 0 in the flush cycle, and the next cycle accepts with an empty scoreboard.
// - in_valid=0: no accept, bubble issued, counters still decrement.
// - Async reset asserted mid-stall returns all state to reset values immediately; nothing is issued after release until a new accept.
// STRUCTURE
// - riscv_pkg holds the shared constants: OPC_RTYPE=7'b0110011, OPC_IALU=7'b0010011, OPC_LUI=7'b0110111, NOP_INSTR=32'h0000_0013, and field bit-range localparams.
// - One combinational sub-module, riscv_reg_use_decode: instr -> {rs1, rs2, rd, use_rs1, use_rs2, use_rd}.
// - Top level holds the scoreboard counters, hazard logic, output register and stall counter.
// TESTING (WB_LATENCY=3 unless stated)
// - Reset release, in_valid=0
//   -> issue_valid=0, issue_instr=32'h00000013, in_ready=1, stall_count=0.
// - addi x5,x0,5 then add x6,x5,x1 presented back-to-back
//   -> add stalled 3 cycles, issued 4 cycles after addi; stall_count=3.
// - addi x7,x6,1 followed by independent add x5,x20,x12
//   -> no stall, consecutive issue_valid pulses, stall_count unchanged.
// - addi x0,x20,16 then add x9,x0,x1
//   -> no stall (x0 never busy).
// - LUI x15 then 32'h0 word
//   -> both issued back-to-back; 32'h0 passes through unchanged with issue_valid=1.
// - sub x8,x15,x7 stalling on x7 with flush pulsed in stall cycle 1
//   -> in_ready=0 in the flush cycle; sub accepted the next cycle with no further stall.
// - STALL_W=2 with long stall chains
//   -> stall_count saturates at 3.
// - rst_n low mid-stall
//   -> immediate reset values, busy state cleared.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the issue scoreboard: opcodes, the canonical NOP
// and the instruction field bit ranges used by the register-use decoder.
package riscv_pkg;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [6:0]  OPC_IALU  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPC_HI = 6;
  localparam int OPC_LO = 0;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 7;
  localparam int RS1_HI = 19;
  localparam int RS1_LO = 15;
  localparam int RS2_HI = 24;
  localparam int RS2_LO = 20;

endpackage

// File: rtl/riscv_reg_use_decode.sv
// Combinational decode of which architectural registers an instruction reads
// and writes; unknown opcodes use no registers at all.
module riscv_reg_use_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        use_rd
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = instr[OPC_HI:OPC_LO];
  assign rs1         = instr[RS1_HI:RS1_LO];
  assign rs2         = instr[RS2_HI:RS2_LO];
  assign rd          = instr[RD_HI:RD_LO];
  assign unused_bits = ^{instr[31:25], instr[14:12]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_IALU: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_LUI:  use_rd = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/riscv_issue_scoreboard.sv
// In-order issue stage: holds back instructions whose sources are still in
// flight, issuing NOP bubbles instead, and counts hazard-stall cycles.
module riscv_issue_scoreboard
  import riscv_pkg::*;
#(
  parameter int WB_LATENCY = 3,
  parameter int STALL_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               issue_valid,
  output logic [31:0]        issue_instr,
  output logic [STALL_W-1:0] stall_count
);

  localparam int CNT_W = $clog2(WB_LATENCY + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(WB_LATENCY);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [4:0]       rs1, rs2, rd;
  logic             use_rs1, use_rs2, use_rd;
  logic [CNT_W-1:0] busy_cnt [1:31];
  logic [31:0]      busy;
  logic             hazard;
  logic             accept;

  riscv_reg_use_decode u_decode (
    .instr   (in_instr),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .use_rd  (use_rd)
  );

  // x0 has no counter, so it can never look busy.
  assign busy[0] = 1'b0;

  assign hazard   = in_valid && ((use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]));
  assign in_ready = !hazard && !flush;
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign busy[gi] = (busy_cnt[gi] != '0);

      // A fresh write reload beats the per-cycle countdown (covers WAW too).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          busy_cnt[gi] <= '0;
        end else if (flush) begin
          busy_cnt[gi] <= '0;
        end else if (accept && use_rd && (rd == 5'(gi))) begin
          busy_cnt[gi] <= CNT_LOAD;
        end else if (busy[gi]) begin
          busy_cnt[gi] <= busy_cnt[gi] - CNT_ONE;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_instr <= NOP_INSTR;
    end else if (accept) begin
      issue_valid <= 1'b1;
      issue_instr <= in_instr;
    end else begin
      issue_valid <= 1'b0;
      issue_instr <= NOP_INSTR;
    end
  end

  // Performance counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard && !flush && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_ONE;
    end
  end

endmodule
